// File: rtl/kb_scr_host.sv
// kb_scr_host: terminal-side peer of the keyboard/screen driver.
// Key bytes go out through a strobe/ack handshake; screen bytes are acked and buffered.
module kb_scr_host #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [7:0]               data_o,
  input  logic [7:0]               data_i,
  output logic [1:0]               control_o,
  input  logic [1:0]               control_i,
  input  logic                     kb_valid,
  input  logic [7:0]               kb_data,
  output logic                     kb_ready,
  output logic                     scr_valid,
  output logic [7:0]               scr_data,
  input  logic                     scr_ready,
  output logic                     kb_timeout,
  output logic [$clog2(DEPTH):0]   kb_count,
  output logic [$clog2(DEPTH):0]   scr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STROBE,
    TX_RELEASE
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_t;

  logic [7:0]    r_kb_mem [DEPTH];
  logic [AW-1:0] r_kb_wr;
  logic [AW-1:0] r_kb_rd;
  logic [CW-1:0] r_kb_cnt;
  logic          w_kb_full;
  logic          w_kb_empty;
  logic          w_kb_push;
  logic          w_kb_pop;
  logic [7:0]    w_kb_head;

  logic [7:0]    r_scr_mem [DEPTH];
  logic [AW-1:0] r_scr_wr;
  logic [AW-1:0] r_scr_rd;
  logic [CW-1:0] r_scr_cnt;
  logic          w_scr_full;
  logic          w_scr_empty;
  logic          w_scr_push;
  logic          w_scr_pop;
  logic          w_scr_space;

  tx_state_t     r_tx_st;
  tx_state_t     w_tx_nxt;
  logic          r_wen;
  logic          w_wen_nxt;
  logic [7:0]    r_data;
  logic [7:0]    w_data_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [TW-1:0] w_timer_inc;
  logic          r_timeout;
  logic          w_timeout_nxt;
  logic          w_tx_pop;

  rx_state_t     r_rx_st;
  rx_state_t     w_rx_nxt;
  logic          r_rok;
  logic          w_rok_nxt;
  logic          w_rx_push;

  assign w_kb_full  = (r_kb_cnt == FULL);
  assign w_kb_empty = (r_kb_cnt == '0);
  assign w_kb_head  = r_kb_mem[r_kb_rd];
  assign w_kb_pop   = w_tx_pop & ~w_kb_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_kb_push  = kb_valid & (~w_kb_full | w_kb_pop);

  assign w_scr_full  = (r_scr_cnt == FULL);
  assign w_scr_empty = (r_scr_cnt == '0);
  assign w_scr_pop   = scr_ready & ~w_scr_empty;
  assign w_scr_space = ~w_scr_full | w_scr_pop;
  assign w_scr_push  = w_rx_push;

  assign kb_ready   = ~w_kb_full;
  assign kb_count   = r_kb_cnt;
  assign scr_valid  = ~w_scr_empty;
  assign scr_data   = r_scr_mem[r_scr_rd];
  assign scr_count  = r_scr_cnt;
  assign kb_timeout = r_timeout;
  assign data_o     = r_data;
  assign control_o  = {r_wen, r_rok};

  always_ff @(posedge clk) begin
    if (w_kb_push) r_kb_mem[r_kb_wr] <= kb_data;
    if (w_scr_push) r_scr_mem[r_scr_wr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kb_wr  <= '0;
      r_kb_rd  <= '0;
      r_kb_cnt <= '0;
    end else begin
      if (w_kb_push) r_kb_wr <= r_kb_wr + 1'b1;
      if (w_kb_pop) r_kb_rd <= r_kb_rd + 1'b1;
      unique case ({w_kb_push, w_kb_pop})
        2'b10:   r_kb_cnt <= r_kb_cnt + 1'b1;
        2'b01:   r_kb_cnt <= r_kb_cnt - 1'b1;
        default: r_kb_cnt <= r_kb_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scr_wr  <= '0;
      r_scr_rd  <= '0;
      r_scr_cnt <= '0;
    end else begin
      if (w_scr_push) r_scr_wr <= r_scr_wr + 1'b1;
      if (w_scr_pop) r_scr_rd <= r_scr_rd + 1'b1;
      unique case ({w_scr_push, w_scr_pop})
        2'b10:   r_scr_cnt <= r_scr_cnt + 1'b1;
        2'b01:   r_scr_cnt <= r_scr_cnt - 1'b1;
        default: r_scr_cnt <= r_scr_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st   <= TX_IDLE;
      r_wen     <= 1'b0;
      r_data    <= 8'h00;
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tx_st   <= w_tx_nxt;
      r_wen     <= w_wen_nxt;
      r_data    <= w_data_nxt;
      r_timer   <= w_timer_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // write_ok is active-low: 0 means the driver took the byte.
  always_comb begin
    w_tx_nxt      = r_tx_st;
    w_wen_nxt     = r_wen;
    w_data_nxt    = r_data;
    w_timer_nxt   = r_timer;
    w_timeout_nxt = r_timeout;
    w_tx_pop      = 1'b0;
    w_timer_inc   = r_timer + 1'b1;
    unique case (r_tx_st)
      TX_IDLE: begin
        if (!w_kb_empty) begin
          w_data_nxt  = w_kb_head;
          w_wen_nxt   = 1'b1;
          w_timer_nxt = '0;
          w_tx_nxt    = TX_STROBE;
        end
      end
      TX_STROBE: begin
        if (!control_i[0]) begin
          w_wen_nxt   = 1'b0;
          w_tx_pop    = 1'b1;
          w_timer_nxt = '0;
          w_tx_nxt    = TX_RELEASE;
        end else if (w_timer_inc == TMAX) begin
          w_timeout_nxt = 1'b1;
          w_wen_nxt     = 1'b0;
          w_tx_pop      = 1'b1;
          w_timer_nxt   = '0;
          w_tx_nxt      = TX_IDLE;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      TX_RELEASE: begin
        if (control_i[0]) begin
          w_timer_nxt = '0;
          w_tx_nxt    = TX_IDLE;
        end else if (w_timer_inc == TMAX) begin
          w_timeout_nxt = 1'b1;
          w_timer_nxt   = '0;
          w_tx_nxt      = TX_IDLE;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      default: begin
        w_wen_nxt   = 1'b0;
        w_timer_nxt = '0;
        w_tx_nxt    = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_st <= RX_IDLE;
      r_rok   <= 1'b0;
    end else begin
      r_rx_st <= w_rx_nxt;
      r_rok   <= w_rok_nxt;
    end
  end

  // read_en is active-low; one push per low phase.
  always_comb begin
    w_rx_nxt  = r_rx_st;
    w_rok_nxt = r_rok;
    w_rx_push = 1'b0;
    unique case (r_rx_st)
      RX_IDLE: begin
        if (!control_i[1] && w_scr_space) begin
          w_rx_push = 1'b1;
          w_rok_nxt = 1'b1;
          w_rx_nxt  = RX_ACK;
        end
      end
      RX_ACK: begin
        if (control_i[1]) begin
          w_rok_nxt = 1'b0;
          w_rx_nxt  = RX_IDLE;
        end
      end
      default: begin
        w_rok_nxt = 1'b0;
        w_rx_nxt  = RX_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_kb_scr_host.sv
// Directed bench for kb_scr_host with queue scoreboards per direction.
module tb_kb_scr_host;

  logic       clk;
  logic       rst;
  logic [7:0] data_o;
  logic [7:0] data_i;
  logic [1:0] control_o;
  logic [1:0] control_i;
  logic       kb_valid;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       scr_valid;
  logic [7:0] scr_data;
  logic       scr_ready;
  logic       kb_timeout;
  logic [2:0] kb_count;
  logic [2:0] scr_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_kb[$];
  logic [7:0] exp_scr[$];

  kb_scr_host #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .data_o(data_o),
    .data_i(data_i),
    .control_o(control_o),
    .control_i(control_i),
    .kb_valid(kb_valid),
    .kb_data(kb_data),
    .kb_ready(kb_ready),
    .scr_valid(scr_valid),
    .scr_data(scr_data),
    .scr_ready(scr_ready),
    .kb_timeout(kb_timeout),
    .kb_count(kb_count),
    .scr_count(scr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kb_push(input logic [7:0] b, input logic exp_rdy);
    check("kb_ready", kb_ready, exp_rdy);
    kb_valid = 1'b1;
    kb_data  = b;
    if (exp_rdy) exp_kb.push_back(b);
    step();
    kb_valid = 1'b0;
  endtask

  task automatic wait_wen(input string tag);
    int k;
    k = 0;
    while (!control_o[1] && k < 20) begin
      step();
      k++;
    end
    check(tag, control_o[1], 1'b1);
  endtask

  task automatic kb_expect(input string tag);
    if (exp_kb.size() == 0) check({tag, "_q"}, 1, 0);
    else check(tag, data_o, exp_kb.pop_front());
  endtask

  task automatic tx_take(input string tag);
    wait_wen({tag, "_wen"});
    kb_expect(tag);
    control_i[0] = 1'b0;
    step();
    check({tag, "_drop"}, control_o[1], 1'b0);
    control_i[0] = 1'b1;
    step();
  endtask

  task automatic rx_send(input string tag, input logic [7:0] b);
    int k;
    control_i[1] = 1'b0;
    data_i = b;
    exp_scr.push_back(b);
    k = 0;
    step();
    while (!control_o[0] && k < 10) begin
      step();
      k++;
    end
    check({tag, "_rok"}, control_o[0], 1'b1);
    control_i[1] = 1'b1;
    step();
    check({tag, "_rok0"}, control_o[0], 1'b0);
  endtask

  task automatic scr_take(input string tag);
    if (exp_scr.size() == 0) check({tag, "_q"}, 1, 0);
    else check(tag, scr_data, exp_scr.pop_front());
    scr_ready = 1'b1;
    step();
    scr_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    control_i = 2'b11;
    data_i = 8'h00;
    kb_valid = 1'b0;
    kb_data = 8'h00;
    scr_ready = 1'b0;
    step();
    step();
    check("rst_ctl", control_o, 2'b00);
    check("rst_data", data_o, 8'h00);
    check("rst_kbrdy", kb_ready, 1'b1);
    check("rst_scrv", scr_valid, 1'b0);
    check("rst_to", kb_timeout, 1'b0);
    check("rst_kbc", kb_count, 0);
    check("rst_scrc", scr_count, 0);
    rst = 1'b0;
    step();

    // single key byte
    kb_push(8'h41, 1'b1);
    check("k41_cnt1", kb_count, 1);
    check("k41_wen0", control_o[1], 1'b0);
    step();
    check("k41_wen", control_o[1], 1'b1);
    kb_expect("k41_data");
    step();
    step();
    step();
    check("k41_hold", control_o, 2'b10);
    control_i[0] = 1'b0;
    step();
    check("k41_drop", control_o[1], 1'b0);
    check("k41_cnt0", kb_count, 0);
    control_i[0] = 1'b1;
    step();
    check("k41_idle", control_o, 2'b00);

    // fill to DEPTH, fifth blocked, then drain in order
    kb_push(8'h31, 1'b1);
    kb_push(8'h32, 1'b1);
    kb_push(8'h33, 1'b1);
    kb_push(8'h34, 1'b1);
    kb_push(8'h35, 1'b0);
    check("full_cnt", kb_count, 4);
    for (int i = 0; i < 4; i++) tx_take("order");
    check("drain_cnt", kb_count, 0);
    check("no_to", kb_timeout, 1'b0);

    // strobe timeout
    kb_push(8'h77, 1'b1);
    wait_wen("to_wen");
    kb_expect("to_data");
    n = 0;
    while (control_o[1] && n < 40) begin
      n++;
      step();
    end
    check("to_len", n, 8);
    check("to_flag", kb_timeout, 1'b1);
    check("to_cnt", kb_count, 0);
    kb_push(8'h78, 1'b1);
    tx_take("after_to");
    check("to_sticky", kb_timeout, 1'b1);

    // screen byte, long low phase gives a single push
    control_i[1] = 1'b0;
    data_i = 8'h5A;
    exp_scr.push_back(8'h5A);
    step();
    check("rx_rok", control_o[0], 1'b1);
    check("rx_valid", scr_valid, 1'b1);
    check("rx_data", scr_data, exp_scr[0]);
    for (int i = 0; i < 4; i++) step();
    check("rx_single", scr_count, 1);
    check("rx_hold", control_o[0], 1'b1);
    control_i[1] = 1'b1;
    step();
    check("rx_rok0", control_o[0], 1'b0);
    scr_take("rx_pop");
    check("rx_empty", scr_count, 0);

    // screen backpressure and pointer wrap
    rx_send("f1", 8'hA1);
    rx_send("f2", 8'hA2);
    rx_send("f3", 8'hA3);
    rx_send("f4", 8'hA4);
    check("scr_full", scr_count, 4);
    control_i[1] = 1'b0;
    data_i = 8'hEE;
    exp_scr.push_back(8'hEE);
    step();
    step();
    step();
    check("bp_rok", control_o[0], 1'b0);
    check("bp_cnt", scr_count, 4);
    scr_take("bp_pop");
    n = 0;
    while (!control_o[0] && n < 5) begin
      step();
      n++;
    end
    check("ee_rok", control_o[0], 1'b1);
    control_i[1] = 1'b1;
    step();
    check("ee_cnt", scr_count, 4);
    for (int i = 0; i < 4; i++) scr_take("wrap");
    check("wrap_empty", scr_valid, 1'b0);

    // reset in the middle of both handshakes
    kb_push(8'h55, 1'b1);
    wait_wen("mid_wen");
    control_i[1] = 1'b0;
    data_i = 8'h66;
    step();
    check("mid_ctl", control_o, 2'b11);
    rst = 1'b1;
    step();
    check("mr_ctl", control_o, 2'b00);
    check("mr_kbc", kb_count, 0);
    check("mr_scrc", scr_count, 0);
    check("mr_scrv", scr_valid, 1'b0);
    check("mr_to", kb_timeout, 1'b0);
    rst = 1'b0;
    control_i = 2'b11;
    exp_kb.delete();
    step();
    check("post_ctl", control_o, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
